// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: shares one Avalon-MM slave between a data requester (m0)
// and an instruction requester (m1). Round-robin on ties, one IDLE bubble
// after every transfer, and a per-grant wait timeout that aborts the transfer
// with ERROR_DATA and a one-cycle bus_error pulse.
//
// Handshake: a requester raises read or write with its command and holds it
// stable until a cycle in which its waitrequest is low; that cycle is the
// completion (or abort) cycle. The slave side uses the same rule: the command
// is accepted in the cycle s_waitrequest is low.
module avalon_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   // data requester
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic        m0_waitrequest,
   output logic [31:0] m0_readdata,
   // instruction requester
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic        m1_waitrequest,
   output logic [31:0] m1_readdata,
   // shared slave
   output logic [31:0] s_address,
   output logic        s_read,
   output logic        s_write,
   output logic [31:0] s_writedata,
   output logic [3:0]  s_byteenable,
   input  logic        s_waitrequest,
   input  logic [31:0] s_readdata,
   // status
   output logic        bus_error,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   // A zero timeout still needs a one-bit counter to hold the compare value.
   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_t           state;
   logic             last_grant;
   logic [CNT_W-1:0] wait_cnt;

   logic req0;
   logic req1;
   logic grant_req;
   logic abort;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   assign state_dbg = state;

   // Request line of whichever requester currently owns the slave.
   always_comb begin
      grant_req = 1'b0;
      case (state)
         GRANT0:  grant_req = req0;
         GRANT1:  grant_req = req1;
         default: grant_req = 1'b0;
      endcase
   end

   // Abort only while the owner still requests; a dropped request just ends the grant.
   assign abort = (state != IDLE) && grant_req && (wait_cnt == CNT_LIMIT);

   // Slave command mux and requester response steering.
   always_comb begin
      s_address      = 32'h0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = 32'h0;
      s_byteenable   = 4'h0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_readdata    = s_readdata;
      m1_readdata    = s_readdata;
      bus_error      = 1'b0;
      case (state)
         GRANT0: begin
            s_address      = m0_address;
            s_read         = m0_read;
            s_write        = m0_write;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            m0_waitrequest = s_waitrequest;
            if (abort) begin
               m0_waitrequest = 1'b0;
               m0_readdata    = ERROR_DATA;
               s_read         = 1'b0;
               s_write        = 1'b0;
               bus_error      = 1'b1;
            end
         end
         GRANT1: begin
            s_address      = m1_address;
            s_read         = m1_read;
            s_write        = m1_write;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            m1_waitrequest = s_waitrequest;
            if (abort) begin
               m1_waitrequest = 1'b0;
               m1_readdata    = ERROR_DATA;
               s_read         = 1'b0;
               s_write        = 1'b0;
               bus_error      = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Grant FSM, round-robin pointer and per-grant wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wait_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               if (req0 && req1) begin
                  state <= last_grant ? GRANT0 : GRANT1;
               end else if (req0) begin
                  state <= GRANT0;
               end else if (req1) begin
                  state <= GRANT1;
               end
            end
            GRANT0, GRANT1: begin
               if (!grant_req) begin
                  // owner withdrew mid-transfer: release without moving the pointer
                  state <= IDLE;
               end else if (abort || !s_waitrequest) begin
                  state      <= IDLE;
                  last_grant <= (state == GRANT1);
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning max slave wait cycles per granted transfer before abort.
REQ-002 SHALL have parameter ERROR_DATA, default 32'hDEADBEEF, meaning readdata returned on an aborted transfer.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports m0_address/m1_address  input  32  requester byte address (m0 = data port, m1 = instruction port).
REQ-006 SHALL have ports m0_read/m1_read, m0_write/m1_write  input  1  requester Avalon read/write strobes.
REQ-007 SHALL have ports m0_writedata/m1_writedata  input  32, and m0_byteenable/m1_byteenable  input  4  requester write data and lane enables.
REQ-008 SHALL have ports m0_waitrequest/m1_waitrequest  output  1, and m0_readdata/m1_readdata  output  32  requester stall and read return.
REQ-009 SHALL have ports s_address  output  32, s_read/s_write  output  1, s_writedata  output  32, s_byteenable  output  4  shared slave command.
REQ-010 SHALL have ports s_waitrequest  input  1, s_readdata  input  32  shared slave response.
REQ-011 SHALL have port bus_error  output  1  one-cycle pulse on timeout abort.

Function
REQ-012 SHALL implement states IDLE, GRANT0, GRANT1 plus a 1-bit last_grant pointer and a timeout counter of width clog2(TIMEOUT_CYCLES+1).
REQ-013 SHALL define reqN = mN_read | mN_write.
REQ-014 In IDLE: s_read = s_write = 0; s_address/s_writedata/s_byteenable = 0; both mN_waitrequest = 1.
REQ-015 In IDLE, only req0 -> GRANT0; only req1 -> GRANT1; both -> grant the requester not equal to last_grant; neither -> stay IDLE.
REQ-016 In GRANTn: s_* command outputs SHALL equal mN_* combinationally; mN_waitrequest = s_waitrequest; other master's waitrequest = 1.
REQ-017 mN_readdata SHALL equal s_readdata at all times except on abort (REQ-021); a non-granted master SHALL ignore readdata while waitrequest = 1.
REQ-018 Transfer completes in the GRANTn cycle where reqN = 1 and s_waitrequest = 0; next state IDLE, last_grant <= n.
REQ-019 Latency: request first visible in IDLE at cycle t -> earliest completion at cycle t+1; one IDLE bubble cycle SHALL follow every completion.
REQ-020 Timeout counter SHALL clear on entry to GRANTn and increment each GRANTn cycle with s_waitrequest = 1.
REQ-021 When counter = TIMEOUT_CYCLES in GRANTn: mN_waitrequest = 0, mN_readdata = ERROR_DATA, s_read = s_write = 0, bus_error = 1 that cycle; next state IDLE, last_grant <= n.
REQ-022 If reqN drops while in GRANTn (protocol violation): next state IDLE, last_grant unchanged, no bus_error.
REQ-023 Simultaneous mN_read and mN_write SHALL be forwarded unmodified; arbiter takes no corrective action.
REQ-024 Granted master's command SHALL not be re-sampled or registered; requester holds it stable per Avalon rules.

Reset
REQ-025 reset = 1 at a rising edge SHALL force state IDLE, last_grant = 1 (m0 wins first tie), counter = 0, regardless of in-flight transfer.
REQ-026 During and after reset until a grant: s_read = s_write = 0, m0/m1_waitrequest = 1, bus_error = 0.
REQ-027 A transfer interrupted by reset SHALL not complete to either master; requester re-issues after reset.

Verification
REQ-028 Single read: m1_read=1, m1_address=32'hBFC00000, slave waitrequest low one cycle after grant with s_readdata=32'h24020005 -> s_address=32'hBFC00000, m1_readdata=32'h24020005, m1_waitrequest low exactly one cycle, m0_waitrequest high throughout.
REQ-029 Tie after reset: m0_write (addr 32'hBFC00400, data 32'h0000000A, byteenable 4'hF) and m1_read asserted same cycle -> m0 granted first, then m1 granted after one IDLE bubble.
REQ-030 Round-robin: both masters request continuously for 6 transfers -> grant order 0,1,0,1,0,1.
REQ-031 Timeout: TIMEOUT_CYCLES=4, m0_read granted, s_waitrequest held 1 -> on 5th GRANT0 cycle m0_waitrequest=0, m0_readdata=32'hDEADBEEF, bus_error=1 for one cycle, s_read=0.
REQ-032 Reset mid-transfer: m1_read granted, s_waitrequest=1, reset pulsed -> next cycle IDLE, s_read=0, both waitrequest=1, m1 never sees waitrequest low; subsequent tie grants m0.
REQ-033 Request drop: m0_read granted then deasserted before s_waitrequest falls -> IDLE next cycle, bus_error=0, next tie still grants per prior last_grant.
